// File: rtl/stream_mux_arb.sv
// N-input registered stream multiplexer with valid/ready handshakes.
// Arbitration is fixed priority, round-robin or external select, chosen by MODE.
module stream_mux_arb #(
  parameter int WIDTH = 8,
  parameter int NUM_CH = 4,
  parameter int MODE = 1,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  input  logic                    out_ready
);

  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  grant_idx;
  logic [SEL_W-1:0]  cand;
  logic [SEL_W-1:0]  next_ptr;
  logic [NUM_CH-1:0] grant;
  logic [WIDTH-1:0]  sel_data;
  logic              found;
  logic              can_load;
  logic              load;
  int                scan_idx;

  // Handshake: a word moves on any channel or on the output when valid && ready
  // are both high at a rising edge; in_ready depends on grant and can_load only.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    scan_idx  = 0;
    if (MODE == 2) begin
      if (int'(sel) < NUM_CH && in_valid[sel]) begin
        found     = 1'b1;
        grant_idx = sel;
      end
    end else begin
      // Scan starts at rr_ptr for round-robin, at 0 for fixed priority.
      for (int off = 0; off < NUM_CH; off++) begin
        scan_idx = (MODE == 1) ? int'(rr_ptr) + off : off;
        if (scan_idx >= NUM_CH) scan_idx = scan_idx - NUM_CH;
        cand = SEL_W'(scan_idx);
        if (!found && in_valid[cand]) begin
          found     = 1'b1;
          grant_idx = cand;
        end
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    can_load = !out_valid || out_ready;
    in_ready = (can_load && !rst) ? grant : '0;
    load     = found && can_load && !rst;
    sel_data = in_data[grant_idx*WIDTH +: WIDTH];
    next_ptr = (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (can_load) begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_ch    <= grant_idx;
        if (MODE == 1) rr_ptr <= next_ptr;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
